// File: rtl/layer2_checker.sv
// layer2_checker: password checking stage of a brute-force lock search.
// Each request captures a candidate, scrambles it over ROUNDS rounds and compares
// the result with Target. The first matching candidate is kept in FoundPW.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - synchronous active-high reset
//   goL2     - request, held high until doneL2 is seen
//   Din      - candidate, valid the cycle before goL2 rises
//   Target   - scrambled lock value, static during operation
//   doneL2   - registered completion flag, held until goL2 drops
//   RD       - registered "keep searching" flag (~Found)
//   Found    - sticky match flag
//   FoundPW  - first candidate that matched
//   Attempts - (ATTEMPT_CNT_EN only) saturating count of compares performed
//
// Optional feature: define ATTEMPT_CNT_EN to add the Attempts counter output.
module layer2_checker #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       goL2,
  input  logic [7:0] Din,
  input  logic [7:0] Target,
  output logic       doneL2,
  output logic       RD,
  output logic       Found,
  output logic [7:0] FoundPW
`ifdef ATTEMPT_CNT_EN
  ,
  output logic [8:0] Attempts
`endif
);

  typedef enum logic [1:0] {StIdle, StHash, StCmp, StDone} state_e;

  localparam logic [3:0] LastRnd = 4'(ROUNDS - 1);

  state_e     r_state, w_state_d;
  logic       r_go;
  logic [7:0] r_din;
  logic [7:0] r_x, w_x_d;
  logic [7:0] r_cand, w_cand_d;
  logic [3:0] r_rnd, w_rnd_d;
  logic       r_done, w_done_d;
  logic       r_found, w_found_d;
  logic       r_rd;
  logic [7:0] r_pw, w_pw_d;
  logic       w_cmp_entry;
  logic [7:0] w_mix;

  // One scramble round: rotate left by one, then XOR with a round-dependent key.
  assign w_mix = {r_x[6:0], r_x[7]} ^ (8'h5A + {4'b0000, r_rnd});

  always_comb begin
    w_state_d   = r_state;
    w_x_d       = r_x;
    w_cand_d    = r_cand;
    w_rnd_d     = r_rnd;
    w_done_d    = 1'b0;
    w_found_d   = r_found;
    w_pw_d      = r_pw;
    w_cmp_entry = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Only a fresh rising edge of goL2 starts a request.
        if (goL2 && !r_go) begin
          w_state_d = StHash;
          w_cand_d  = r_din;
          w_x_d     = r_din;
          w_rnd_d   = 4'd0;
        end
      end
      StHash: begin
        if (!goL2) begin
          w_state_d = StIdle;
        end else begin
          w_x_d   = w_mix;
          w_rnd_d = r_rnd + 4'd1;
          if (r_rnd == LastRnd) begin
            w_state_d   = StCmp;
            w_cmp_entry = 1'b1;
          end
        end
      end
      StCmp: begin
        if (!goL2) begin
          w_state_d = StIdle;
        end else begin
          // Found is sticky: later matches never overwrite the first password.
          if ((r_x == Target) && !r_found) begin
            w_found_d = 1'b1;
            w_pw_d    = r_cand;
          end
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (goL2) begin
          w_done_d = 1'b1;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_go    <= 1'b0;
      r_din   <= 8'h00;
      r_x     <= 8'h00;
      r_cand  <= 8'h00;
      r_rnd   <= 4'd0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_rd    <= 1'b1;
      r_pw    <= 8'h00;
    end else begin
      r_state <= w_state_d;
      r_go    <= goL2;
      r_din   <= Din;
      r_x     <= w_x_d;
      r_cand  <= w_cand_d;
      r_rnd   <= w_rnd_d;
      r_done  <= w_done_d;
      r_found <= w_found_d;
      r_rd    <= ~w_found_d;
      r_pw    <= w_pw_d;
    end
  end

  assign doneL2  = r_done;
  assign RD      = r_rd;
  assign Found   = r_found;
  assign FoundPW = r_pw;

`ifdef ATTEMPT_CNT_EN
  logic [8:0] r_attempts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_attempts <= 9'd0;
    end else if (w_cmp_entry && (r_attempts != 9'd511)) begin
      r_attempts <= r_attempts + 9'd1;
    end
  end

  assign Attempts = r_attempts;
`endif

endmodule

// File: tb/tb_layer2_checker.sv
module tb_layer2_checker;

  localparam int unsigned ROUNDS = 4;

  logic       clk;
  logic       reset;
  logic       goL2;
  logic [7:0] Din;
  logic [7:0] Target;
  logic       doneL2;
  logic       RD;
  logic       Found;
  logic [7:0] FoundPW;
`ifdef ATTEMPT_CNT_EN
  logic [8:0] Attempts;
`endif

  layer2_checker #(.ROUNDS(ROUNDS)) dut (
    .clk    (clk),
    .reset  (reset),
    .goL2   (goL2),
    .Din    (Din),
    .Target (Target),
    .doneL2 (doneL2),
    .RD     (RD),
    .Found  (Found),
    .FoundPW(FoundPW)
`ifdef ATTEMPT_CNT_EN
    ,
    .Attempts(Attempts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       found;
    logic [7:0] pw;
    logic       rd;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic       m_found = 1'b0;
  logic [7:0] m_pw = 8'h00;
  int         m_attempts = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_hash(input logic [7:0] d);
    logic [7:0] x;
    x = d;
    for (int r = 0; r < int'(ROUNDS); r++) begin
      x = {x[6:0], x[7]} ^ (8'h5A + 8'(r));
    end
    return x;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    goL2  = 1'b0;
    Din   = 8'h00;
    tick();
    tick();
    reset      = 1'b0;
    m_found    = 1'b0;
    m_pw       = 8'h00;
    m_attempts = 0;
    sb.delete();
  endtask

  // Full handshake: present candidate, raise goL2, wait for doneL2, drop goL2.
  task automatic run_request(input logic [7:0] d);
    exp_t e;
    int   n;
    tick();
    Din = d;
    tick();
    goL2 = 1'b1;
    if ((model_hash(d) == Target) && !m_found) begin
      m_found = 1'b1;
      m_pw    = d;
    end
    if (m_attempts < 511) m_attempts++;
    e.found = m_found;
    e.pw    = m_pw;
    e.rd    = ~m_found;
    sb.push_back(e);
    n = 0;
    while (!doneL2 && n < 40) begin
      tick();
      n++;
    end
    check("latency", 32'(n - 1), 32'(ROUNDS + 2));
    e = sb.pop_front();
    check("found", 32'(Found), 32'(e.found));
    check("foundpw", 32'(FoundPW), 32'(e.pw));
    check("rd", 32'(RD), 32'(e.rd));
`ifdef ATTEMPT_CNT_EN
    check("attempts", 32'(Attempts), 32'(m_attempts));
`endif
    goL2 = 1'b0;
    tick();
    check("done_clear", 32'(doneL2), 32'd0);
  endtask

  initial begin
    logic seen;
    int   n;
    reset  = 1'b1;
    goL2   = 1'b0;
    Din    = 8'h00;
    Target = 8'h00;
    tick();
    tick();
    check("rst_done", 32'(doneL2), 32'd0);
    check("rst_found", 32'(Found), 32'd0);
    check("rst_rd", 32'(RD), 32'd1);
    check("rst_pw", 32'(FoundPW), 32'd0);
    reset = 1'b0;

    // Single matching candidate.
    Target = 8'h5A;
    run_request(8'h00);

    // Sweep: first match on candidate 3, then a later match must not overwrite it.
    do_reset();
    Target = 8'h6A;
    for (int c = 0; c < 4; c++) run_request(8'(c));
    check("sweep_pw", 32'(FoundPW), 32'h03);
    Target = 8'h5A;
    run_request(8'h00);
    check("sticky_pw", 32'(FoundPW), 32'h03);

    // Abort two cycles into scrambling a matching candidate.
    do_reset();
    Target = 8'h5A;
    tick();
    Din = 8'h00;
    tick();
    goL2 = 1'b1;
    tick();
    tick();
    tick();
    goL2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | doneL2;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_found", 32'(Found), 32'd0);
    check("abort_pw", 32'(FoundPW), 32'd0);
    run_request(8'h00);

    // Random target and candidates.
    do_reset();
    Target = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) run_request(8'($urandom_range(0, 255)));
    run_request(8'h00);

    // Reset while holding doneL2.
    do_reset();
    Target = 8'h5A;
    tick();
    Din = 8'h00;
    tick();
    goL2 = 1'b1;
    n = 0;
    while (!doneL2 && n < 40) begin
      tick();
      n++;
    end
    check("pre_rst_done", 32'(doneL2), 32'd1);
    check("pre_rst_found", 32'(Found), 32'd1);
    reset = 1'b1;
    goL2  = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_in_done_done", 32'(doneL2), 32'd0);
    check("rst_in_done_found", 32'(Found), 32'd0);
    check("rst_in_done_rd", 32'(RD), 32'd1);
    check("rst_in_done_pw", 32'(FoundPW), 32'd0);
    m_found    = 1'b0;
    m_pw       = 8'h00;
    m_attempts = 0;
    sb.delete();
    run_request(8'h00);

`ifdef ATTEMPT_CNT_EN
    do_reset();
    Target = 8'h77;
    for (int i = 0; i < 5; i++) run_request(8'(i));
    check("attempts_5", 32'(Attempts), 32'd5);
    for (int i = 0; i < 515; i++) run_request(8'(i));
    check("attempts_sat", 32'(Attempts), 32'd511);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer2_checker.md
LAYER2_CHECKER -- requirements
Module: layer2_checker

Interface
REQ-001 SHALL have parameter ROUNDS, default 4; number of scramble rounds, legal range 1..8.
REQ-002 SHALL have port clk, input, 1 bit; single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port goL2, input, 1 bit; request from the password generator, held high until doneL2 is seen.
REQ-005 SHALL have port Din, input, 8 bits; candidate password, valid for one cycle immediately before goL2 rises.
REQ-006 SHALL have port Target, input, 8 bits; scrambled lock value, static during operation.
REQ-007 SHALL have port doneL2, output, 1 bit; registered completion flag for the request.
REQ-008 SHALL have port RD, output, 1 bit; registered "keep searching" flag, equal to ~Found.
REQ-009 SHALL have port Found, output, 1 bit; sticky match flag.
REQ-010 SHALL have port FoundPW, output, 8 bits; first candidate that matched.

Function
REQ-011 SHALL sample Din into din_q and goL2 into go_q every cycle.
REQ-012 SHALL implement states IDLE, HASH, CMP and DONE.
REQ-013 IDLE SHALL detect a request when goL2=1 and go_q=0, then latch cand=din_q and x=din_q, set rnd=0 and go to HASH.
REQ-014 In HASH, each cycle SHALL set x = rotl1(x) XOR (8'h5A + rnd) with 8-bit wrap and increment rnd; after ROUNDS cycles it SHALL go to CMP.
REQ-015 CMP SHALL compare x with Target; on a match with Found=0 it SHALL set Found=1 and FoundPW=cand; it SHALL then go to DONE.
REQ-016 On a match with Found=1, the first FoundPW SHALL be retained.
REQ-017 DONE SHALL hold doneL2=1 until goL2 is sampled 0, then go to IDLE; doneL2 SHALL be 0 in the IDLE cycle.
REQ-018 Latency: with goL2 first sampled high at edge T, doneL2 SHALL be high from edge T+ROUNDS+2.
REQ-019 If goL2 drops in HASH or CMP, the block SHALL abort to IDLE with no doneL2 pulse and no change to Found or FoundPW.
REQ-020 A goL2 that is already high on leaving DONE SHALL NOT start a new request; a new request needs a fresh rising edge.
REQ-021 RD SHALL fall on the same edge that Found rises and SHALL stay low until reset.

Reset
REQ-022 Reset SHALL force state=IDLE, doneL2=0, Found=0, FoundPW=0, RD=1, and din_q, go_q, x, cand and rnd to 0.
REQ-023 Reset asserted mid-HASH or in DONE SHALL take priority and discard the in-flight request.

Configuration
REQ-024 Macro ATTEMPT_CNT_EN SHALL add output Attempts[8:0], cleared by reset and incremented on each CMP entry, saturating at 511.
REQ-025 With ATTEMPT_CNT_EN undefined, the Attempts port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-026 Target=8'h5A, Din=8'h00, then goL2 held -> doneL2 high 6 cycles after goL2 is sampled, Found=1, FoundPW=8'h00, RD=0.
REQ-027 Target=8'h6A, candidates 0..3 via full handshakes -> Found first rises on candidate 3, FoundPW=8'h03, RD=1 for candidates 0..2.
REQ-028 Found=1, then a later request also matches (Target=8'h5A, Din=8'h00 repeated) -> doneL2 handshake completes, FoundPW unchanged.
REQ-029 goL2 dropped 2 cycles into HASH -> no doneL2, state returns to IDLE, Found unchanged.
REQ-030 reset pulsed while in DONE -> next cycle doneL2=0, Found=0, RD=1; a following request completes normally.
REQ-031 With ATTEMPT_CNT_EN, 5 requests -> Attempts=5; after 520 requests -> Attempts=511.
